// File: rtl/sim_pkg.sv
// sim_pkg: shared FSM encoding, trap encoding default, lane-packing widths
// and small lane-mask helpers for the commit monitor slice.
package sim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_TRAP    = 2'd2,
        ST_TIMEOUT = 2'd3
    } mon_state_e;

    localparam logic [31:0] TRAP_INSTR_DEF = 32'h8000_0000;
    localparam int          PC_W           = 32;
    localparam int          INSTR_W        = 32;
    localparam int          CODE_W         = 8;
    localparam int          MAX_LANES      = 4;

    // Keep valid lanes up to and including the lowest-index trap lane.
    function automatic logic [MAX_LANES-1:0] lanes_upto_trap(
        input logic [MAX_LANES-1:0] valid,
        input logic [MAX_LANES-1:0] hit
    );
        logic [MAX_LANES-1:0] keep;
        logic                 found;
        keep  = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (!found) keep[i] = valid[i];
            if (hit[i]) found = 1'b1;
        end
        return keep;
    endfunction

    // Number of set lanes in a mask.
    function automatic logic [2:0] lane_popcount(input logic [MAX_LANES-1:0] m);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < MAX_LANES; i++) n = n + {2'b00, m[i]};
        return n;
    endfunction

endpackage

// File: rtl/sim_commit_monitor_if.sv
// sim_commit_monitor_if: commit lanes from the core plus the commit-log
// drain port. The core/bench side is master, the monitor is slave.
interface sim_commit_monitor_if #(
    parameter int LANES = 2
);
    import sim_pkg::*;

    logic [LANES-1:0]         commit_valid;
    logic [PC_W*LANES-1:0]    commit_pc;
    logic [INSTR_W*LANES-1:0] commit_instr;
    logic [CODE_W-1:0]        trap_code_i;

    logic                     log_valid;
    logic                     log_ready;
    logic [LANES-1:0]         log_mask;
    logic [PC_W*LANES-1:0]    log_pc;
    logic [INSTR_W*LANES-1:0] log_instr;
    logic                     log_overflow;

    modport master (
        output commit_valid, commit_pc, commit_instr, trap_code_i, log_ready,
        input  log_valid, log_mask, log_pc, log_instr, log_overflow
    );

    modport slave (
        input  commit_valid, commit_pc, commit_instr, trap_code_i, log_ready,
        output log_valid, log_mask, log_pc, log_instr, log_overflow
    );

endinterface

// File: rtl/commit_log_fifo.sv
// commit_log_fifo: first-word-fall-through FIFO for commit log entries.
// Pointers carry one extra bit so full and empty are distinguishable.
// A push into a full FIFO is dropped and latches a sticky overflow flag,
// unless a pop happens in the same cycle.
module commit_log_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             pop_valid,
    output logic [WIDTH-1:0] pop_data,
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_p1, rd_ptr_p1;
    logic             empty, full, do_pop, do_push, drop;

    assign empty     = (wr_ptr_p1 == rd_ptr_p1);
    assign full      = (wr_ptr_p1[AW] != rd_ptr_p1[AW]) &&
                       (wr_ptr_p1[AW-1:0] == rd_ptr_p1[AW-1:0]);
    assign do_pop    = !empty && pop_ready;
    assign do_push   = push && (!full || do_pop);
    assign drop      = push && full && !do_pop;
    assign pop_valid = !empty;
    assign pop_data  = empty ? '0 : mem[rd_ptr_p1[AW-1:0]];

    // Entry storage; reads are masked while empty so no reset is needed.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr_p1[AW-1:0]] <= push_data;
    end

    // Read/write pointers and the sticky overflow flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_p1 <= '0;
            rd_ptr_p1 <= '0;
            overflow  <= 1'b0;
        end else begin
            if (do_push) wr_ptr_p1 <= wr_ptr_p1 + (AW+1)'(1);
            if (do_pop)  rd_ptr_p1 <= rd_ptr_p1 + (AW+1)'(1);
            if (drop)    overflow  <= 1'b1;
        end
    end

endmodule

// File: rtl/sim_commit_monitor.sv
// sim_commit_monitor: simulation-side retirement monitor. Counts cycles and
// retired instructions, detects the halt (trap) instruction, and raises a
// watchdog timeout when the core stops committing.
// Optional commit log FIFO is built when COMMIT_LOG_EN is defined; otherwise
// all log outputs are tied low and log_ready is ignored.
module sim_commit_monitor
    import sim_pkg::*;
#(
    parameter int          LANES       = 2,
    parameter int          CNT_W       = 64,
    parameter int          FIFO_DEPTH  = 8,
    parameter int          TIMEOUT_CYC = 10000,
    parameter logic [31:0] TRAP_INSTR  = TRAP_INSTR_DEF
) (
    input  logic                clock,
    input  logic                reset_n,
    sim_commit_monitor_if.slave bus,
    output logic [CNT_W-1:0]    cycle_cnt,
    output logic [CNT_W-1:0]    instr_cnt,
    output logic [1:0]          state_o,
    output logic                trap_valid,
    output logic [CODE_W-1:0]   trap_code,
    output logic [PC_W-1:0]     trap_pc,
    output logic                timeout
);
    localparam int              WD_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC);

    mon_state_e        state_p1, state_d;
    logic [WD_W-1:0]   wd_p1, wd_d, wd_inc;
    logic [CNT_W-1:0]  cycle_p1, instr_p1;
    logic              trap_valid_p1, timeout_p1;
    logic [CODE_W-1:0] trap_code_p1;
    logic [PC_W-1:0]   trap_pc_p1, trap_pc_sel;
    logic [LANES-1:0]  trap_hit, lane_keep;
    logic              any_valid, active, trap_take;

    assign any_valid = |bus.commit_valid;
    assign active    = (state_p1 == ST_IDLE) || (state_p1 == ST_RUN);
    assign trap_take = (state_p1 == ST_RUN) && (|trap_hit);
    assign lane_keep = trap_take
                     ? LANES'(lanes_upto_trap(MAX_LANES'(bus.commit_valid), MAX_LANES'(trap_hit)))
                     : bus.commit_valid;

    // Per-lane trap match; scanning downward leaves the lowest-index pc selected.
    always_comb begin
        trap_hit    = '0;
        trap_pc_sel = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            trap_hit[i] = bus.commit_valid[i] &&
                          (bus.commit_instr[INSTR_W*i +: INSTR_W] == TRAP_INSTR);
            if (trap_hit[i]) trap_pc_sel = bus.commit_pc[PC_W*i +: PC_W];
        end
    end

    // Next state and watchdog; a commit on the limit cycle clears the watchdog.
    always_comb begin
        state_d = state_p1;
        wd_d    = wd_p1;
        wd_inc  = wd_p1 + WD_W'(1);
        case (state_p1)
            ST_IDLE: begin
                if (any_valid) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (trap_take) begin
                    state_d = ST_TRAP;
                end else if (any_valid) begin
                    wd_d = '0;
                end else begin
                    wd_d = wd_inc;
                    if (wd_inc == WD_LIMIT) state_d = ST_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    // State, watchdog, counters and trap/timeout capture; counters freeze once terminal.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_p1      <= ST_IDLE;
            wd_p1         <= '0;
            cycle_p1      <= '0;
            instr_p1      <= '0;
            trap_valid_p1 <= 1'b0;
            trap_code_p1  <= '0;
            trap_pc_p1    <= '0;
            timeout_p1    <= 1'b0;
        end else begin
            state_p1 <= state_d;
            wd_p1    <= wd_d;
            if (active) begin
                cycle_p1 <= cycle_p1 + CNT_W'(1);
                instr_p1 <= instr_p1 + CNT_W'(lane_popcount(MAX_LANES'(lane_keep)));
            end
            if (trap_take) begin
                trap_valid_p1 <= 1'b1;
                trap_code_p1  <= bus.trap_code_i;
                trap_pc_p1    <= trap_pc_sel;
            end
            if ((state_p1 == ST_RUN) && (state_d == ST_TIMEOUT)) timeout_p1 <= 1'b1;
        end
    end

    assign cycle_cnt  = cycle_p1;
    assign instr_cnt  = instr_p1;
    assign state_o    = state_p1;
    assign trap_valid = trap_valid_p1;
    assign trap_code  = trap_code_p1;
    assign trap_pc    = trap_pc_p1;
    assign timeout    = timeout_p1;

`ifdef COMMIT_LOG_EN
    localparam int ENTRY_W = LANES + (PC_W + INSTR_W) * LANES;

    logic               log_push;
    logic [ENTRY_W-1:0] log_head;

    assign log_push = active && any_valid;

    commit_log_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_log_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (log_push),
        .push_data ({lane_keep, bus.commit_pc, bus.commit_instr}),
        .pop_ready (bus.log_ready),
        .pop_valid (bus.log_valid),
        .pop_data  (log_head),
        .overflow  (bus.log_overflow)
    );

    assign {bus.log_mask, bus.log_pc, bus.log_instr} = log_head;
`else
    logic unused_log_ready;

    assign unused_log_ready = bus.log_ready;
    assign bus.log_valid    = 1'b0;
    assign bus.log_mask     = '0;
    assign bus.log_pc       = '0;
    assign bus.log_instr    = '0;
    assign bus.log_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_sim_commit_monitor.sv
// tb_sim_commit_monitor: directed bench with a queue-based reference model
// and a per-cycle compare process, plus literal expectations at key points.
module tb_sim_commit_monitor;
    import sim_pkg::*;

    localparam int          LANES       = 2;
    localparam int          CNT_W       = 8;
    localparam int          FIFO_DEPTH  = 4;
    localparam int          TIMEOUT_CYC = 16;
    localparam logic [31:0] TRAP        = 32'h8000_0000;
    localparam logic [31:0] NOP         = 32'h0000_0013;

    logic             clock   = 1'b0;
    logic             reset_n = 1'b1;
    logic [CNT_W-1:0] cycle_cnt, instr_cnt;
    logic [1:0]       state_o;
    logic             trap_valid, timeout;
    logic [7:0]       trap_code;
    logic [31:0]      trap_pc;

    int tests = 0;
    int fails = 0;

    sim_commit_monitor_if #(.LANES(LANES)) bus();

    sim_commit_monitor #(
        .LANES       (LANES),
        .CNT_W       (CNT_W),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TRAP_INSTR  (TRAP)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .bus        (bus),
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt),
        .state_o    (state_o),
        .trap_valid (trap_valid),
        .trap_code  (trap_code),
        .trap_pc    (trap_pc),
        .timeout    (timeout)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [LANES-1:0] mask;
        logic [63:0]      pc;
        logic [63:0]      instr;
    } ent_t;

    logic [CNT_W-1:0] m_cycle = '0, m_instr = '0;
    bit               m_started = 0, m_trapped = 0, m_timed = 0, m_ovf = 0;
    int               m_idle = 0;
    logic [31:0]      m_trap_pc = '0;
    logic [7:0]       m_trap_code = '0;
    ent_t             m_q[$];

    task automatic model_reset();
        m_cycle = '0; m_instr = '0;
        m_started = 0; m_trapped = 0; m_timed = 0; m_ovf = 0;
        m_idle = 0; m_trap_pc = '0; m_trap_code = '0;
        m_q.delete();
    endtask

    task automatic model_update();
        logic [LANES-1:0] v, kept;
        int   tl;
        bit   act, pop, room;
        ent_t e;
        if (!reset_n) begin
            model_reset();
            return;
        end
        v    = bus.commit_valid;
        act  = !m_trapped && !m_timed;
        pop  = (m_q.size() != 0) && (bus.log_ready == 1'b1);
        room = (m_q.size() < FIFO_DEPTH) || pop;
        kept = v;
        tl   = -1;
        if (act && m_started)
            for (int i = 0; i < LANES; i++)
                if (tl < 0 && v[i] && bus.commit_instr[32*i +: 32] == TRAP) tl = i;
        if (tl >= 0)
            for (int i = 0; i < LANES; i++)
                if (i > tl) kept[i] = 1'b0;
        if (pop) void'(m_q.pop_front());
        if (act) begin
            m_cycle = m_cycle + CNT_W'(1);
            m_instr = m_instr + CNT_W'($countones(kept));
            if (v != 0) begin
                if (room) begin
                    e.mask = kept; e.pc = bus.commit_pc; e.instr = bus.commit_instr;
                    m_q.push_back(e);
                end else begin
                    m_ovf = 1;
                end
            end
            if (tl >= 0) begin
                m_trapped   = 1;
                m_trap_pc   = bus.commit_pc[32*tl +: 32];
                m_trap_code = bus.trap_code_i;
            end else if (m_started) begin
                if (v != 0) m_idle = 0;
                else begin
                    m_idle++;
                    if (m_idle == TIMEOUT_CYC) m_timed = 1;
                end
            end
            if (v != 0) m_started = 1;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    initial forever begin
        logic        e_lv, e_ovf;
        logic [1:0]  e_mask, e_state;
        logic [63:0] e_pc, e_in;
        @(negedge clock);
        e_state = m_timed ? 2'd3 : m_trapped ? 2'd2 : m_started ? 2'd1 : 2'd0;
        e_lv = 1'b0; e_ovf = 1'b0; e_mask = '0; e_pc = '0; e_in = '0;
`ifdef COMMIT_LOG_EN
        if (m_q.size() != 0) begin
            e_lv = 1'b1; e_mask = m_q[0].mask; e_pc = m_q[0].pc; e_in = m_q[0].instr;
        end
        e_ovf = m_ovf;
`endif
        check("state_o",      state_o,          e_state);
        check("cycle_cnt",    cycle_cnt,        m_cycle);
        check("instr_cnt",    instr_cnt,        m_instr);
        check("trap_valid",   trap_valid,       m_trapped);
        check("trap_pc",      trap_pc,          m_trap_pc);
        check("trap_code",    trap_code,        m_trap_code);
        check("timeout",      timeout,          m_timed);
        check("log_valid",    bus.log_valid,    e_lv);
        check("log_mask",     bus.log_mask,     e_mask);
        check("log_pc",       bus.log_pc,       e_pc);
        check("log_instr",    bus.log_instr,    e_in);
        check("log_overflow", bus.log_overflow, e_ovf);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] i0,
                        input logic [31:0] pc1, input logic [31:0] i1,
                        input logic [7:0] code, input logic rdy);
        bus.commit_valid = v;
        bus.commit_pc    = {pc1, pc0};
        bus.commit_instr = {i1, i0};
        bus.trap_code_i  = code;
        bus.log_ready    = rdy;
        @(posedge clock);
        model_update();
        @(negedge clock);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int k = 0; k < n; k++) step(2'b00, '0, '0, '0, '0, 8'h00, rdy);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"},   state_o,          0);
        check({tag, "_cycle"},   cycle_cnt,        0);
        check({tag, "_instr"},   instr_cnt,        0);
        check({tag, "_trapv"},   trap_valid,       0);
        check({tag, "_trappc"},  trap_pc,          0);
        check({tag, "_trapcd"},  trap_code,        0);
        check({tag, "_tmo"},     timeout,          0);
        check({tag, "_logv"},    bus.log_valid,    0);
        check({tag, "_logmask"}, bus.log_mask,     0);
        check({tag, "_logpc"},   bus.log_pc,       0);
        check({tag, "_logins"},  bus.log_instr,    0);
        check({tag, "_logovf"},  bus.log_overflow, 0);
    endtask

    // Assert reset mid-cycle, check outputs clear at once, then release.
    task automatic reset_mid(input string tag);
        #2 reset_n = 1'b0;
        #1 check_all_zero(tag);
        model_reset();
        idle(1, 1'b0);
        reset_n = 1'b1;
    endtask

    // ---------------- directed sequences ----------------
    initial begin
        bus.commit_valid = '0; bus.commit_pc = '0; bus.commit_instr = '0;
        bus.trap_code_i = '0;  bus.log_ready = 1'b0;
        #1 reset_n = 1'b0;
        idle(2, 1'b0);
        check_all_zero("por");
        reset_n = 1'b1;

        // Idle cycles still count; then four lane-0 commits.
        idle(3, 1'b0);
        check("idle_state", state_o, 0);
        check("idle_cycle", cycle_cnt, 3);
        for (int k = 0; k < 4; k++) step(2'b01, 32'h1c00_0000 + 32'(4*k), NOP, '0, '0, 8'h00, 1'b0);
        check("run_state", state_o, 1);
        check("run_instr", instr_cnt, 4);
        check("run_cycle", cycle_cnt, 7);

        // Commit on the 16th quiet cycle keeps the monitor running.
        idle(15, 1'b0);
        step(2'b11, 32'h1c00_0010, NOP, 32'h1c00_0014, NOP, 8'h00, 1'b0);
        check("wd_save_state", state_o, 1);
        check("wd_save_tmo", timeout, 0);
        check("wd_save_cycle", cycle_cnt, 23);
        check("wd_save_instr", instr_cnt, 6);

        // Sixteen quiet cycles trigger the timeout.
        idle(15, 1'b0);
        check("wd_15_state", state_o, 1);
        check("wd_15_tmo", timeout, 0);
        idle(1, 1'b0);
        check("tmo_flag", timeout, 1);
        check("tmo_state", state_o, 3);
        check("tmo_cycle", cycle_cnt, 39);
        for (int k = 0; k < 3; k++) step(2'b11, 32'h500, NOP, 32'h504, NOP, 8'h00, 1'b0);
        check("tmo_frozen_cycle", cycle_cnt, 39);
        check("tmo_frozen_instr", instr_cnt, 6);
        reset_mid("rst_a");

        // Trap on lane 1 with both lanes valid.
        step(2'b01, 32'h100, NOP, '0, '0, 8'h00, 1'b0);
        step(2'b11, 32'h200, NOP, 32'h204, TRAP, 8'h00, 1'b0);
        check("trap_v", trap_valid, 1);
        check("trap_pc_l1", trap_pc, 32'h204);
        check("trap_code0", trap_code, 8'h00);
        check("trap_instr", instr_cnt, 3);
        check("trap_cycle", cycle_cnt, 2);
        check("trap_state", state_o, 2);
        step(2'b11, 32'h208, NOP, 32'h20c, NOP, 8'h77, 1'b0);
        check("trap_frz_instr", instr_cnt, 3);
        check("trap_frz_cycle", cycle_cnt, 2);
        check("trap_frz_code", trap_code, 8'h00);
        reset_mid("rst_b");

        // Both lanes trap: lane 0 wins, one instruction counted.
        step(2'b01, 32'h2fc, NOP, '0, '0, 8'h00, 1'b0);
        step(2'b11, 32'h300, TRAP, 32'h304, TRAP, 8'h5a, 1'b0);
        check("dual_pc", trap_pc, 32'h300);
        check("dual_instr", instr_cnt, 2);
        check("dual_code", trap_code, 8'h5a);
        reset_mid("rst_c");

        // Trap encoding on an invalid lane 0 is ignored.
        step(2'b01, 32'h3fc, NOP, '0, '0, 8'h00, 1'b0);
        step(2'b10, 32'h400, TRAP, 32'h404, TRAP, 8'ha5, 1'b0);
        check("inv0_pc", trap_pc, 32'h404);
        check("inv0_instr", instr_cnt, 2);
        check("inv0_code", trap_code, 8'ha5);
        reset_mid("rst_d");

        // Log FIFO: fill past depth, then drain in order.
        for (int k = 0; k < 5; k++) step(2'b01, 32'h1000 + 32'(4*k), NOP + 32'(k), '0, '0, 8'h00, 1'b0);
`ifdef COMMIT_LOG_EN
        check("log_full_v", bus.log_valid, 1);
        check("log_full_ovf", bus.log_overflow, 1);
        check("log_head_pc", bus.log_pc, 64'h0000_0000_0000_1000);
        check("log_head_mask", bus.log_mask, 2'b01);
`endif
        for (int k = 0; k < 4; k++) begin
            idle(1, 1'b1);
`ifdef COMMIT_LOG_EN
            if (k < 3) check("log_drain_pc", bus.log_pc, 64'(32'h1004 + 32'(4*k)));
            else       check("log_drain_empty", bus.log_valid, 0);
`endif
        end
        reset_mid("rst_e");

        // Push and pop together while full: no drop.
        for (int k = 0; k < 4; k++) step(2'b01, 32'h2000 + 32'(4*k), NOP, '0, '0, 8'h00, 1'b0);
        step(2'b01, 32'h2010, NOP, '0, '0, 8'h00, 1'b1);
`ifdef COMMIT_LOG_EN
        check("pp_ovf", bus.log_overflow, 0);
        check("pp_valid", bus.log_valid, 1);
        check("pp_head", bus.log_pc, 64'h0000_0000_0000_2004);
`endif
        step(2'b01, 32'h2014, NOP, '0, '0, 8'h00, 1'b1);
        reset_mid("rst_mid_drain");

        // Counter wrap at 8 bits.
        for (int k = 0; k < 140; k++) step(2'b11, 32'h3000, NOP, 32'h3004, NOP, 8'h00, (k % 3) != 0);
        check("wrap1_cycle", cycle_cnt, 140);
        check("wrap1_instr", instr_cnt, 24);
        for (int k = 0; k < 120; k++) step(2'b01, 32'h4000, NOP, '0, '0, 8'h00, (k % 2) != 0);
        check("wrap2_cycle", cycle_cnt, 4);
        check("wrap2_instr", instr_cnt, 144);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        tests++;
        fails++;
        $display("FAIL sim_time_limit: got expired, expected finish before limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sim_commit_monitor.md
SIM_COMMIT_MONITOR -- requirements
Module: sim_commit_monitor

Interface
REQ-001 SHALL have parameter LANES, default 2, number of commit lanes per cycle (1..4).
REQ-002 SHALL have parameter CNT_W, default 64, width of cycle/instruction counters.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, log FIFO entries (power of two, >=2).
REQ-004 SHALL have parameter TIMEOUT_CYC, default 10000, idle-commit cycles before timeout.
REQ-005 SHALL have parameter TRAP_INSTR, default 32'h80000000, halt instruction encoding.
REQ-006 SHALL have ports: clock  in  1  clock; reset_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports: commit_valid  in  LANES  per-lane commit strobe; commit_pc  in  32*LANES  lane i at [32i+31:32i]; commit_instr  in  32*LANES  same packing; trap_code_i  in  8  exit code sampled at trap.
REQ-008 SHALL have ports: cycle_cnt  out  CNT_W; instr_cnt  out  CNT_W; state_o  out  2  FSM state; trap_valid  out  1; trap_code  out  8; trap_pc  out  32; timeout  out  1.
REQ-009 SHALL have ports (log feature only): log_valid  out  1; log_ready  in  1; log_mask  out  LANES; log_pc  out  32*LANES; log_instr  out  32*LANES; log_overflow  out  1  sticky drop flag.

Function
REQ-010 FSM SHALL have states IDLE=0, RUN=1, TRAP=2, TIMEOUT=3; IDLE->RUN on any commit_valid bit.
REQ-011 RUN->TRAP SHALL occur when any valid lane carries TRAP_INSTR; lowest-index such lane wins.
REQ-012 On trap entry, trap_valid=1, trap_pc=winning lane pc, trap_code=trap_code_i, all held until reset.
REQ-013 RUN->TIMEOUT SHALL occur after TIMEOUT_CYC consecutive RUN cycles with commit_valid==0; timeout=1 held.
REQ-014 Watchdog counter SHALL clear on any commit and count only in RUN.
REQ-015 Commit in the same cycle the watchdog reaches TIMEOUT_CYC SHALL win: no timeout, stay RUN.
REQ-016 TRAP and TIMEOUT SHALL be terminal; only reset exits.
REQ-017 cycle_cnt SHALL increment each cycle in IDLE/RUN, freeze in terminal states, wrap modulo 2^CNT_W.
REQ-018 instr_cnt SHALL add popcount of valid lanes each cycle in IDLE/RUN; on trap cycle counts lanes up to and including the trap lane only; wraps.
REQ-019 All counters and outputs SHALL be registered: values reflect commits one cycle after sampling.

Reset
REQ-020 reset_n low SHALL asynchronously force state IDLE, counters/watchdog 0, trap_valid 0, trap_code 0, trap_pc 0, timeout 0.
REQ-021 Log FIFO SHALL empty on reset: log_valid 0, log_overflow 0, log_mask/pc/instr 0; reset mid-drain discards entries.

Configuration
REQ-022 Macro COMMIT_LOG_EN defined: log FIFO and REQ-009 ports present.
REQ-023 Without COMMIT_LOG_EN: no FIFO storage; log_valid, log_mask, log_pc, log_instr, log_overflow tied 0; log_ready ignored.
REQ-024 Log FIFO SHALL push one entry (mask+pc+instr of all lanes) per cycle with any valid lane in IDLE/RUN, trap-cycle mask truncated per REQ-018.
REQ-025 Pop SHALL occur on log_valid && log_ready; log outputs show FIFO head, first-word-fall-through.
REQ-026 Push when full with no pop SHALL drop entry and set log_overflow sticky; push+pop when full SHALL both succeed.
REQ-027 Pointers SHALL wrap at FIFO_DEPTH; full/empty via extra pointer bit.

Structure
REQ-028 State encodings, TRAP_INSTR default and lane-packing width constants SHALL live in shared package sim_pkg.
REQ-029 FIFO SHALL be sub-module commit_log_fifo, instantiated only under COMMIT_LOG_EN.

Verification
REQ-030 Reset, then lane0 commits pc 1c000000..1c00000c for 4 cycles -> state RUN, instr_cnt=4, cycle_cnt counts every cycle.
REQ-031 Both lanes valid, lane1 instr=80000000, trap_code_i=0 -> trap_valid=1, trap_pc=lane1 pc, instr_cnt+=2, counters frozen next cycle.
REQ-032 Lane0 and lane1 both TRAP_INSTR -> trap_pc=lane0 pc, instr_cnt+=1.
REQ-033 TIMEOUT_CYC=16, commits stop in RUN -> timeout=1 exactly 16 cycles later; commit at cycle 16 -> stays RUN.
REQ-034 COMMIT_LOG_EN, FIFO_DEPTH=4, log_ready=0, 5 commit cycles -> 4 entries, log_overflow=1; then log_ready=1 -> 4 pops in order, log_valid drops.
REQ-035 reset_n asserted mid-run with FIFO non-empty -> all outputs zero same cycle, state IDLE.
